// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with an explicit occupancy counter.
// Read data is the combinational head entry; storage itself is not reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the uart transmitter: issues one wr_en pulse per byte
// and paces itself on tx_busy so no byte is written while a frame is in flight.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [7:0]    m_din,
  output logic          m_wr_en,
  input  logic          m_tx_busy,
  output logic [AW:0]   level,
  output logic          idle
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_din;
  logic        r_wr_en;
  logic [7:0]  w_rdata;
  logic [AW:0] w_level;
  logic        w_push;
  logic        w_pop;

  assign s_ready = (w_level != (AW+1)'(DEPTH));
  assign w_push  = s_valid && s_ready;
  assign w_pop   = (r_state == S_IDLE) && (w_level != '0) && !m_tx_busy;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk_50m),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (s_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_level (w_level)
  );

  // wr_en is set on entry to LOAD so it is high exactly while state == LOAD.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_din   <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_din   <= w_rdata;
          r_wr_en <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD:      r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (m_tx_busy)  r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (!m_tx_busy) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign m_din   = r_din;
  assign m_wr_en = r_wr_en;
  assign level   = w_level;
  assign idle    = (w_level == '0) && (r_state == S_IDLE) && !m_tx_busy;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a clocked uart busy model plus a queue-based
// reference of the byte order, directed vectors and randomized streams.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk_50m = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  wire         s_ready;
  wire  [7:0]  m_din;
  wire         m_wr_en;
  wire  [AW:0] level;
  wire         idle;

  logic        force_busy = 1'b0;
  int          ucnt = 0;
  int          ulen = 10;
  bit          rand_len = 1'b0;
  int          viol = 0;
  logic [7:0]  prev_din = 8'h00;
  logic [7:0]  wr_q[$];

  wire m_tx_busy = force_busy || (ucnt > 0);

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_din     (m_din),
    .m_wr_en   (m_wr_en),
    .m_tx_busy (m_tx_busy),
    .level     (level),
    .idle      (idle)
  );

  always #10 clk_50m = ~clk_50m;

  // uart transmit model: busy rises the cycle after wr_en and holds for a frame.
  always @(posedge clk_50m) begin
    if (m_wr_en) begin
      wr_q.push_back(m_din);
      if (m_tx_busy) viol++;
      ucnt <= rand_len ? int'($urandom_range(1, 12)) : ulen;
    end else if (ucnt > 0) begin
      ucnt <= ucnt - 1;
    end
    if (!rst && m_tx_busy && (m_din != prev_din)) viol++;
    prev_din <= m_din;
  end

  typedef struct {
    logic [7:0]  data;
    logic [AW:0] exp_lvl;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t       tbl [4];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         wbase = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d, input int max_wait);
    s_data  = d;
    s_valid = 1'b1;
    for (int k = 0; k < max_wait && s_ready !== 1'b1; k++) tick();
    if (s_ready !== 1'b1) chk("push_timeout", {31'd0, s_ready}, 32'd1);
    else exp_q.push_back(d);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_wait, input string nm);
    for (int k = 0; k < max_wait && idle !== 1'b1; k++) tick();
    chk(nm, {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_busy(input logic v, input int max_wait, input string nm);
    for (int k = 0; k < max_wait && m_tx_busy !== v; k++) tick();
    chk(nm, {31'd0, m_tx_busy}, {31'd0, v});
  endtask

  task automatic compare_out(input string nm);
    int n;
    int bad;
    n   = wr_q.size() - wbase;
    bad = 0;
    chk({nm, "_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (wr_q[wbase + i] !== exp_q[i]) bad++;
    chk({nm, "_order"}, bad, 0);
    wbase = wr_q.size();
    exp_q.delete();
  endtask

  task automatic stream(input int n, input bit pat);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      d = pat ? 8'((i * 7) % 256) : 8'($urandom);
      push_one(d, 2000);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    tbl[0] = '{data: 8'hA5, exp_lvl: 5'd1, exp_din: 8'hA5};
    tbl[1] = '{data: 8'h00, exp_lvl: 5'd1, exp_din: 8'h00};
    tbl[2] = '{data: 8'hFF, exp_lvl: 5'd1, exp_din: 8'hFF};
    tbl[3] = '{data: 8'h3C, exp_lvl: 5'd1, exp_din: 8'h3C};

    // reset held three cycles
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_level",   level, 32'd0);
    chk("rst_wr_en",   {31'd0, m_wr_en}, 32'd0);
    chk("rst_idle",    {31'd0, idle}, 32'd1);
    chk("rst_din",     m_din, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {31'd0, idle}, 32'd1);

    // single-byte latency vectors
    for (int i = 0; i < 4; i++) begin
      p0 = wr_q.size();
      s_data  = tbl[i].data;
      s_valid = 1'b1;
      if (s_ready === 1'b1) exp_q.push_back(tbl[i].data);
      tick();
      s_valid = 1'b0;
      chk("vec_level_t1", level, tbl[i].exp_lvl);
      chk("vec_wr_en_t1", {31'd0, m_wr_en}, 32'd0);
      tick();
      chk("vec_wr_en_t2", {31'd0, m_wr_en}, 32'd1);
      chk("vec_din_t2",   m_din, tbl[i].exp_din);
      tick();
      chk("vec_wr_en_t3", {31'd0, m_wr_en}, 32'd0);
      wait_idle(60, "vec_idle");
      chk("vec_level_end", level, 32'd0);
      chk("vec_pulses", wr_q.size() - p0, 32'd1);
      compare_out("vec");
    end

    // burst to full with the transmitter held busy
    force_busy = 1'b1;
    p0 = wr_q.size();
    for (int i = 0; i < 16; i++) push_one(8'(i), 50);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    chk("full_level",   level, 32'd16);
    chk("full_no_pulse", wr_q.size() - p0, 32'd0);

    // full boundary: pop, then push in the same cycle as the next pop
    force_busy = 1'b0;
    tick();
    chk("full_pop_level", level, 32'd15);
    chk("full_pop_wr_en", {31'd0, m_wr_en}, 32'd1);
    chk("full_pop_ready", {31'd0, s_ready}, 32'd1);
    wait_busy(1'b1, 50, "full_busy_rise");
    wait_busy(1'b0, 50, "full_busy_fall");
    tick();
    s_data  = 8'hEE;
    s_valid = 1'b1;
    if (s_ready === 1'b1) exp_q.push_back(8'hEE);
    tick();
    s_valid = 1'b0;
    chk("pushpop_level", level, 32'd15);
    chk("pushpop_wr_en", {31'd0, m_wr_en}, 32'd1);
    tick();
    chk("pushpop_level_hold", level, 32'd15);
    wait_idle(2000, "burst_drain_idle");
    chk("burst_pulses", wr_q.size() - p0, 32'd17);
    compare_out("burst");

    // transmitter busy externally with three bytes queued
    force_busy = 1'b1;
    push_one(8'h11, 10);
    push_one(8'h22, 10);
    push_one(8'h33, 10);
    chk("hold_level", level, 32'd3);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
        if (m_wr_en !== 1'b0 || m_din !== 8'hEE) bad++;
        tick();
      end
      chk("hold_quiet", bad, 32'd0);
    end
    force_busy = 1'b0;
    chk("hold_release_wr0", {31'd0, m_wr_en}, 32'd0);
    tick();
    chk("hold_release_wr1", {31'd0, m_wr_en}, 32'd1);
    chk("hold_release_din", m_din, 32'h11);
    wait_idle(500, "hold_idle");
    compare_out("hold");

    // reset while waiting for a long frame with five bytes buffered
    ulen = 30;
    for (int i = 0; i < 6; i++) push_one(8'h60 + 8'(i), 10);
    repeat (3) tick();
    chk("mid_level", level, 32'd5);
    chk("mid_busy",  {31'd0, m_tx_busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_level", level, 32'd0);
    chk("mid_rst_ready", {31'd0, s_ready}, 32'd1);
    chk("mid_rst_wr_en", {31'd0, m_wr_en}, 32'd0);
    rst = 1'b0;
    p0 = wr_q.size();
    wait_busy(1'b0, 100, "mid_frame_end");
    repeat (10) tick();
    chk("mid_no_more_wr", wr_q.size() - p0, 32'd0);
    chk("mid_idle", {31'd0, idle}, 32'd1);
    chk("mid_sent_one", wr_q.size() - wbase, 32'd1);
    chk("mid_sent_byte", wr_q[wbase], 32'h60);
    wbase = wr_q.size();
    exp_q.delete();

    // wrap-around with pattern i*7 and random gaps
    ulen = 3;
    stream(40, 1'b1);
    wait_idle(4000, "wrap_idle");
    compare_out("wrap");

    // random data, random valid gaps, random frame lengths
    rand_len = 1'b1;
    stream(150, 1'b0);
    wait_idle(4000, "rand_idle");
    chk("rand_level", level, 32'd0);
    compare_out("rand");

    chk("protocol_viol", viol, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
